// File: rtl/score_disp_pkg.sv
// -----------------------------------------------------------------------------
// score_disp_pkg
// Shared definitions for the score display driver:
//   - state_e    : conversion FSM state encoding
//   - SEG_BLANK  : all segments off (active-low)
//   - SEG_TABLE  : BCD digit -> active-low segment code, seg[6:0] = g,f,e,d,c,b,a
//   - CUR_BASE / HIGH_BASE : first display digit of each score
//   - dd_step()  : one double-dabble iteration on the {bcd, bin} working word
// -----------------------------------------------------------------------------
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV_CUR,
    ST_CONV_HIGH,
    ST_COMMIT
  } state_e;

  localparam int BIN_W  = 8;
  localparam int BCD_W  = 12;
  localparam int WORK_W = BCD_W + BIN_W;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed directly by the 4-bit BCD value; codes 10..15 never occur but
  // decode to blank so the table covers the full index range.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  localparam logic [2:0] CUR_BASE  = 3'd0;
  localparam logic [2:0] HIGH_BASE = 3'd4;

  // Add 3 to every BCD nibble >= 5, then shift the whole {bcd, bin} word left.
  // Nibbles never exceed 9 before the adjust, so the +3 cannot carry out.
  function automatic logic [WORK_W-1:0] dd_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] t;
    t = w;
    for (int i = 0; i < 3; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
        t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

endpackage

// File: rtl/score_display_driver_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational BCD digit to active-low seven-segment code.
// Ports:
//   bcd   in  4  BCD digit 0..9
//   blank in  1  force all segments off
//   seg   out 7  active-low segments, seg[6:0] = g,f,e,d,c,b,a
// -----------------------------------------------------------------------------
module seg7_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_TABLE[bcd];
  end

endmodule

// File: rtl/score_display_driver.sv
// -----------------------------------------------------------------------------
// score_display_driver
// Renders the live score and the high score on an 8-digit common-anode
// seven-segment display. Each score is converted to 3 BCD digits by a
// sequential double-dabble FSM (8 cycles per score, then an atomic commit),
// and the digits are time-multiplexed by a refresh divider.
//
// Digit map (an[0] rightmost): 0..2 current ones/tens/hundreds, 3 blank,
//                              4..6 high ones/tens/hundreds, 7 blank.
//
// Build option: define SCORE_LEADING_ZERO_BLANK_EN to blank leading zeros of
// each score (hundreds when 0, tens when hundreds and tens are 0).
//
// Parameters:
//   SCORE_W     width of each score input (fixed at 8)
//   REFRESH_DIV clk cycles each digit stays lit (>= 2)
// Ports:
//   clk           in  1  system clock
//   rst_n         in  1  synchronous active-low reset
//   current_score in  8  live score, binary
//   high_score    in  8  high score, binary
//   an            out 8  digit anodes, active-low
//   seg           out 7  segments, active-low, g..a
//   dp            out 1  decimal point, active-low, always off
//   busy          out 1  conversion in flight
// -----------------------------------------------------------------------------
module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int SCORE_W     = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] current_score,
  input  logic [SCORE_W-1:0] high_score,
  output logic [7:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               busy
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Conversion datapath
  state_e              state_q, state_d;
  logic [2:0]          iter_q, iter_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [WORK_W-1:0]   step_w;
  logic [BCD_W-1:0]    res_cur_q, res_cur_d;
  logic [SCORE_W-1:0]  cap_cur_q, cap_cur_d;
  logic [SCORE_W-1:0]  cap_high_q, cap_high_d;
  logic [BCD_W-1:0]    disp_cur_q, disp_cur_d;
  logic [BCD_W-1:0]    disp_high_q, disp_high_d;
  logic                busy_q, busy_d;

  // Refresh / output path
  logic [CNT_W-1:0]    refresh_cnt_q, refresh_cnt_d;
  logic [2:0]          digit_idx_q, digit_idx_d;
  logic [7:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [BCD_W-1:0]    sel_bcd;
  logic [2:0]          sel_pos;
  logic [3:0]          sel_digit;
  logic                sel_blank;
  logic [6:0]          dec_seg;

  assign step_w = dd_step(work_q);

  // Conversion FSM next state. Inputs that change while busy are not queued:
  // the IDLE compare against the captured pair picks them up afterwards.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    iter_d      = iter_q;
    work_d      = work_q;
    res_cur_d   = res_cur_q;
    cap_cur_d   = cap_cur_q;
    cap_high_d  = cap_high_q;
    disp_cur_d  = disp_cur_q;
    disp_high_d = disp_high_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (current_score != cap_cur_q || high_score != cap_high_q) begin
          cap_cur_d  = current_score;
          cap_high_d = high_score;
          work_d     = {{BCD_W{1'b0}}, current_score};
          busy_d     = 1'b1;
          state_d    = ST_CONV_CUR;
        end
      end

      ST_CONV_CUR: begin
        work_d = step_w;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          // Park the current-score result and reuse the working word.
          res_cur_d = step_w[WORK_W-1:BIN_W];
          work_d    = {{BCD_W{1'b0}}, cap_high_q};
          state_d   = ST_CONV_HIGH;
        end
      end

      ST_CONV_HIGH: begin
        work_d = step_w;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        // Both scores land on the same edge so the display is always a
        // coherent pair.
        disp_cur_d  = res_cur_q;
        disp_high_d = work_q[WORK_W-1:BIN_W];
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Digit selection for the currently lit position.
  always_comb begin
    sel_bcd   = disp_cur_q;
    sel_pos   = digit_idx_q - CUR_BASE;
    sel_digit = 4'd0;
    sel_blank = 1'b0;

    if (digit_idx_q >= HIGH_BASE) begin
      sel_bcd = disp_high_q;
      sel_pos = digit_idx_q - HIGH_BASE;
    end

    case (sel_pos)
      3'd0:    sel_digit = sel_bcd[3:0];
      3'd1:    sel_digit = sel_bcd[7:4];
      3'd2:    sel_digit = sel_bcd[11:8];
      default: sel_blank = 1'b1;
    endcase

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (sel_pos == 3'd2 && sel_bcd[11:8] == 4'd0) sel_blank = 1'b1;
    if (sel_pos == 3'd1 && sel_bcd[11:4] == 8'd0) sel_blank = 1'b1;
`endif
  end

  seg7_decoder u_seg7_decoder (
    .bcd   (sel_digit),
    .blank (sel_blank),
    .seg   (dec_seg)
  );

  // Refresh divider and registered anode/segment outputs. an and seg are
  // computed from the same digit index so they always change together.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      digit_idx_d   = digit_idx_q + 3'd1;
    end
    an_d  = ~(8'd1 << digit_idx_q);
    seg_d = dec_seg;
  end

  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values of the others regardless of statement order.
    if (!rst_n) begin
      // NOTE: the working word and parked result are reset too, so a reset
      // mid-conversion cannot leak a partial result into a later commit.
      state_q       <= ST_IDLE;
      iter_q        <= '0;
      work_q        <= '0;
      res_cur_q     <= '0;
      cap_cur_q     <= '0;
      cap_high_q    <= '0;
      disp_cur_q    <= '0;
      disp_high_q   <= '0;
      busy_q        <= 1'b0;
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
    end else begin
      state_q       <= state_d;
      iter_q        <= iter_d;
      work_q        <= work_d;
      res_cur_q     <= res_cur_d;
      cap_cur_q     <= cap_cur_d;
      cap_high_q    <= cap_high_d;
      disp_cur_q    <= disp_cur_d;
      disp_high_q   <= disp_high_d;
      busy_q        <= busy_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = busy_q;

endmodule

// File: tb/tb_score_display_driver.sv
// -----------------------------------------------------------------------------
// tb_score_display_driver
// Self-checking bench for score_display_driver with REFRESH_DIV = 4.
// A transaction-level reference model (17-edge conversion latency, decimal
// digits by division, digit slot from the edge count) predicts an/seg/busy on
// every cycle; table vectors and hand sequences add targeted checks.
// -----------------------------------------------------------------------------
module tb_score_display_driver;

  localparam int DIV = 4;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ    = 7'h7F;
  localparam bit         LZ_EN = 1'b1;
`else
  localparam logic [6:0] LZ    = 7'h40;
  localparam bit         LZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] current_score;
  logic [7:0] high_score;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  score_display_driver #(
    .SCORE_W     (8),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .current_score (current_score),
    .high_score    (high_score),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int cur, input int high);
    int v, place, hund, tens;
    if (idx == 3 || idx == 7) return 7'h7F;
    v     = (idx < 4) ? cur : high;
    place = idx % 4;
    hund  = v / 100;
    tens  = (v / 10) % 10;
    if (LZ_EN && place == 2 && hund == 0) return 7'h7F;
    if (LZ_EN && place == 1 && hund == 0 && tens == 0) return 7'h7F;
    if (place == 0) return digit_code(v % 10);
    if (place == 1) return digit_code(tens);
    return digit_code(hund);
  endfunction

  int         m_edges, m_left, m_cap_cur, m_cap_high, m_disp_cur, m_disp_high;
  bit         m_busy;
  logic [7:0] m_an;
  logic [6:0] m_seg;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_edges     <= 0;
      m_left      <= 0;
      m_busy      <= 1'b0;
      m_cap_cur   <= 0;
      m_cap_high  <= 0;
      m_disp_cur  <= 0;
      m_disp_high <= 0;
      m_an        <= 8'hFF;
      m_seg       <= 7'h7F;
    end else begin
      m_an    <= ~(8'd1 << ((m_edges / DIV) % 8));
      m_seg   <= exp_seg((m_edges / DIV) % 8, m_disp_cur, m_disp_high);
      m_edges <= m_edges + 1;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy      <= 1'b0;
          m_disp_cur  <= m_cap_cur;
          m_disp_high <= m_cap_high;
        end
        m_left <= m_left - 1;
      end else if (int'(current_score) != m_cap_cur || int'(high_score) != m_cap_high) begin
        m_cap_cur  <= int'(current_score);
        m_cap_high <= int'(high_score);
        m_busy     <= 1'b1;
        m_left     <= 17;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      check("mon_an",   {24'd0, an},  {24'd0, m_an});
      check("mon_seg",  {25'd0, seg}, {25'd0, m_seg});
      check("mon_busy", {31'd0, busy}, {31'd0, m_busy});
      check("mon_dp",   {31'd0, dp},  32'd1);
    end
  endtask

  // Inputs were just changed; expect one 17-sample busy window.
  task automatic run_conv(input string tag);
    int hi   = 0;
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (busy) begin
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_len"}, hi, 32'd17);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check({tag, "_idle"}, {31'd0, done}, 32'd1);
    tick();
  endtask

  // Observe 32 edges (every digit slot at least once) and compare each digit.
  task automatic sweep_check(input string tag, input logic [7:0][6:0] segs);
    logic [6:0] got [8];
    for (int i = 0; i < 8; i++) got[i] = 7'h00;
    for (int k = 0; k < 32; k++) begin
      tick();
      for (int i = 0; i < 8; i++) begin
        if (an == ~(8'd1 << i)) got[i] = seg;
      end
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_digit%0d", tag, i), {25'd0, got[i]}, {25'd0, segs[i]});
    end
  endtask

  typedef struct packed {
    logic [7:0]      cur;
    logic [7:0]      high;
    logic [7:0][6:0] segs;  // element i = expected seg code of digit i
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{8'd255, 8'd0,   {7'h7F, LZ,    LZ,    7'h40, 7'h7F, 7'h24, 7'h12, 7'h12}};
    vecs[1] = '{8'd255, 8'd123, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h7F, 7'h24, 7'h12, 7'h12}};
    vecs[2] = '{8'd9,   8'd123, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h7F, LZ,    LZ,    7'h10}};
    vecs[3] = '{8'd100, 8'd50,  {7'h7F, LZ,    7'h12, 7'h40, 7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[4] = '{8'd0,   8'd200, {7'h7F, 7'h24, 7'h40, 7'h40, 7'h7F, LZ,    LZ,    7'h40}};

    rst_n         = 1'b0;
    current_score = 8'd0;
    high_score    = 8'd0;
    mon_en        = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_an",   {24'd0, an},  32'hFF);
    check("rst_seg",  {25'd0, seg}, 32'h7F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dp",   {31'd0, dp},  32'd1);
    rst_n = 1'b1;
    tick();
    check("post_rst_an",  {24'd0, an},  32'hFE);
    check("post_rst_seg", {25'd0, seg}, 32'h40);

    // Table-driven conversions
    foreach (vecs[v]) begin
      current_score = vecs[v].cur;
      high_score    = vecs[v].high;
      run_conv($sformatf("vec%0d", v));
      sweep_check($sformatf("vec%0d", v), vecs[v].segs);
    end

    // Score changes 100 -> 9 three cycles into a conversion
    begin
      bit ok;
      int lo;
      current_score = 8'd100;
      repeat (3) tick();
      current_score = 8'd9;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        tick();
        if (!busy) ok = 1'b1;
      end
      check("mid_first_commit", {31'd0, ok}, 32'd1);
      ok = 1'b0;
      lo = 1;
      for (int i = 0; i < 10 && !ok; i++) begin
        tick();
        if (busy) ok = 1'b1;
        else lo++;
      end
      check("mid_restart", {31'd0, ok}, 32'd1);
      check("mid_gap", lo, 32'd1);
      wait_idle("mid");
      sweep_check("mid_final", {7'h7F, 7'h24, 7'h40, 7'h40, 7'h7F, LZ, LZ, 7'h10});
    end

    // Refresh sweep: align to the start of digit 0's slot, then 32 edges
    begin
      bit         aligned = 1'b0;
      logic [7:0] prev_an = an;
      for (int i = 0; i < 40 && !aligned; i++) begin
        tick();
        if (an == 8'hFE && prev_an != 8'hFE) aligned = 1'b1;
        prev_an = an;
      end
      check("sweep_align", {31'd0, aligned}, 32'd1);
      for (int k = 0; k < 32; k++) begin
        check($sformatf("sweep_an_%0d", k), {24'd0, an}, {24'd0, ~(8'd1 << (k / 4))});
        if (k / 4 == 3 || k / 4 == 7) check($sformatf("sweep_blank_%0d", k), {25'd0, seg}, 32'h7F);
        tick();
      end
      check("sweep_wrap", {24'd0, an}, 32'hFE);
    end

    // Randomized score traffic, including changes mid-conversion
    for (int r = 0; r < 40; r++) begin
      current_score = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) high_score = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 30)) tick();
    end
    wait_idle("rand");
    repeat (40) tick();

    // Reset during CONV_HIGH
    high_score = high_score + 8'd1;
    repeat (11) tick();
    check("convhigh_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n         = 1'b0;
    current_score = 8'd0;
    high_score    = 8'd0;
    tick();
    check("midrst_an",   {24'd0, an},  32'hFF);
    check("midrst_seg",  {25'd0, seg}, 32'h7F);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_rel_an",  {24'd0, an},  32'hFE);
    check("midrst_rel_seg", {25'd0, seg}, 32'h40);
    begin
      bit never_busy = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (busy) never_busy = 1'b0;
      end
      check("midrst_no_conv", {31'd0, never_busy}, 32'd1);
    end
    sweep_check("midrst_zero", {7'h7F, LZ, LZ, 7'h40, 7'h7F, LZ, LZ, 7'h40});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
